// File: rtl/ssp_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssp_tx_pkg
// Description : Shared types and constants for the SSP transmit serialiser.
//               - tx_state_e : serialiser state (IDLE, SHIFT, GAP)
//               - DSS_MIN    : smallest frame-size code honoured (4-bit frame)
//               - BITCNT_W   : bit-counter width
//               - HALFCNT_W  : SCK half-period counter width
//               - frame_msb(): index of the first bit sent for a DSS code
// Revision    : 1.0 - initial release
// ============================================================================
package ssp_tx_pkg;

  localparam int BITCNT_W  = 4;
  localparam int HALFCNT_W = 8;

  localparam logic [BITCNT_W-1:0] DSS_MIN = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_e;

  // Reserved size codes 0-2 collapse onto the 4-bit frame, so the first
  // transmitted bit index (Nb-1) is never below DSS_MIN.
  function automatic logic [BITCNT_W-1:0] frame_msb(input logic [BITCNT_W-1:0] dss);
    return (dss < DSS_MIN) ? DSS_MIN : dss;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssp_tx_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : ssp_tx_shifter_if
// Description : Bundle of the transmit serialiser's configuration, FIFO and
//               serial-line signals.
//               Configuration : SSE, DSS[3:0], SCR[7:0]
//               FIFO side     : TxDataAvlblSync, TxFRdData[DW-1:0], TxFRdPtrInc
//               Serial side   : SSPTXD, SSPCLKOUT, SSPFSSOUT, TxBSY
//               modport master : drives configuration and FIFO head
//               modport slave  : the serialiser itself
// Revision    : 1.0 - initial release
// ============================================================================
interface ssp_tx_shifter_if
  import ssp_tx_pkg::*;
#(
  parameter int DW = 16
);

  logic                 SSE;
  logic [BITCNT_W-1:0]  DSS;
  logic [HALFCNT_W-1:0] SCR;
  logic                 TxDataAvlblSync;
  logic [DW-1:0]        TxFRdData;
  logic                 TxFRdPtrInc;
  logic                 SSPTXD;
  logic                 SSPCLKOUT;
  logic                 SSPFSSOUT;
  logic                 TxBSY;

  modport master (
    output SSE, DSS, SCR, TxDataAvlblSync, TxFRdData,
    input  TxFRdPtrInc, SSPTXD, SSPCLKOUT, SSPFSSOUT, TxBSY
  );

  modport slave (
    input  SSE, DSS, SCR, TxDataAvlblSync, TxFRdData,
    output TxFRdPtrInc, SSPTXD, SSPCLKOUT, SSPFSSOUT, TxBSY
  );

endinterface
`default_nettype wire

// File: rtl/ssp_tx_shifter_sck_div.sv
`default_nettype none
// ============================================================================
// Module      : ssp_sck_div
// Description : SCK half-period divider. Counts 0..SCR while enabled; each
//               terminal count toggles the SCK level. Held cleared (count 0,
//               SCK low) whenever disabled so every frame starts from a
//               clean low clock.
//   clk    in   SSP clock
//   rst    in   asynchronous active-high reset
//   en_i   in   run enable
//   scr_i  in   half-period minus one, in SSPCLK cycles
//   tick_o out  terminal-count pulse (combinational, valid while enabled)
//   sck_o  out  registered SCK level
//   fall_o out  pulse on the edge that takes SCK from 1 to 0
// Revision    : 1.0 - initial release
// ============================================================================
module ssp_sck_div
  import ssp_tx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [HALFCNT_W-1:0] scr_i,
  output logic                 tick_o,
  output logic                 sck_o,
  output logic                 fall_o
);

  logic [HALFCNT_W-1:0] cnt_q, cnt_d;
  logic                 sck_q, sck_d;

  // '>=' rather than '==' keeps the divider from running the whole counter
  // range if SCR is lowered under a live count.
  assign tick_o = en_i && (cnt_q >= scr_i);
  assign fall_o = tick_o && sck_q;
  assign sck_o  = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (tick_o) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ssp_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : ssp_tx_shifter
// Description : SSP transmit serialiser (SSPCLK domain). Pops one word from
//               the transmit FIFO by toggling TxFRdPtrInc and shifts it out
//               as a Motorola SPI mode-0 frame (SPO=0, SPH=0), MSB first.
//   SSPCLK   in   SSP clock
//   SSPRST   in   asynchronous active-high reset
//   bus      slave modport of ssp_tx_shifter_if:
//              SSE, DSS, SCR, TxDataAvlblSync, TxFRdData      (inputs)
//              TxFRdPtrInc, SSPTXD, SSPCLKOUT, SSPFSSOUT, TxBSY (outputs)
// Parameters  : HOLDOFF - cycles after a pop during which the FIFO-available
//                         flag is ignored (toggle round trip), >= 1
//               DW      - FIFO data width, >= 16
// Revision    : 1.0 - initial release
// ============================================================================
module ssp_tx_shifter
  import ssp_tx_pkg::*;
#(
  parameter int HOLDOFF = 6,
  parameter int DW      = 16
)
(
  input  logic             SSPCLK,
  input  logic             SSPRST,
  ssp_tx_shifter_if.slave  bus
);

  localparam int HO_W = $clog2(HOLDOFF + 1);

  tx_state_e             state_q;
  logic                  ptr_inc_q;
  logic                  txd_q;
  logic                  fss_q;
  logic                  bsy_q;
  logic [DW-1:0]         shreg_q;
  logic [BITCNT_W-1:0]   bitcnt_q;
  logic [HALFCNT_W-1:0]  gapcnt_q;
  logic [HO_W-1:0]       holdoff_q, holdoff_d;

  logic                  start;
  logic [BITCNT_W-1:0]   msb;
  logic [7:0]            shamt;
  logic [DW-1:0]         load_d;
  logic                  sck_en;
  logic                  sck_tick;
  logic                  sck_level;
  logic                  sck_fall;

  assign msb   = frame_msb(bus.DSS);
  assign start = (state_q == IDLE) && bus.SSE && bus.TxDataAvlblSync &&
                 (holdoff_q == '0);

  // The frame is left-aligned in the shift register so the bit on the wire
  // is always the register MSB; bits above Nb-1 fall off the top here.
  assign shamt  = 8'(DW - 1) - {4'b0000, msb};
  assign load_d = bus.TxFRdData << shamt;

  // Gated with SSE so an abort also drops SCK on the very next edge.
  assign sck_en = (state_q == SHIFT) && bus.SSE;

  ssp_sck_div u_sck_div (
    .clk    (SSPCLK),
    .rst    (SSPRST),
    .en_i   (sck_en),
    .scr_i  (bus.SCR),
    .tick_o (sck_tick),
    .sck_o  (sck_level),
    .fall_o (sck_fall)
  );

  // Holdoff masks the stale FIFO-available flag until the pop toggle has
  // made its way to the FIFO and back; it runs down in every state.
  always_comb begin
    holdoff_d = holdoff_q;
    if (start) begin
      holdoff_d = HO_W'(HOLDOFF);
    end else if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - 1'b1;
    end
  end

  always_ff @(posedge SSPCLK or posedge SSPRST) begin
    if (SSPRST) begin
      holdoff_q <= '0;
    end else begin
      holdoff_q <= holdoff_d;
    end
  end

  always_ff @(posedge SSPCLK or posedge SSPRST) begin
    if (SSPRST) begin
      state_q   <= IDLE;
      ptr_inc_q <= 1'b0;
      txd_q     <= 1'b0;
      fss_q     <= 1'b1;
      bsy_q     <= 1'b0;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      gapcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SHIFT;
            ptr_inc_q <= ~ptr_inc_q;
            shreg_q   <= load_d;
            txd_q     <= load_d[DW-1];
            fss_q     <= 1'b0;
            bsy_q     <= 1'b1;
            bitcnt_q  <= msb;
          end
        end

        SHIFT: begin
          if (!bus.SSE) begin
            // Abort: the popped word is dropped, no second pop toggle.
            state_q <= IDLE;
            txd_q   <= 1'b0;
            fss_q   <= 1'b1;
            bsy_q   <= 1'b0;
            shreg_q <= '0;
          end else if (sck_tick) begin
            if (sck_fall) begin
              if (bitcnt_q != '0) begin
                shreg_q  <= shreg_q << 1;
                txd_q    <= shreg_q[DW-2];
                bitcnt_q <= bitcnt_q - 1'b1;
              end else begin
                state_q  <= GAP;
                txd_q    <= 1'b0;
                fss_q    <= 1'b1;
                gapcnt_q <= '0;
              end
            end
          end
        end

        GAP: begin
          if (!bus.SSE) begin
            state_q <= IDLE;
            bsy_q   <= 1'b0;
            shreg_q <= '0;
          end else if (gapcnt_q >= bus.SCR) begin
            state_q <= IDLE;
            bsy_q   <= 1'b0;
          end else begin
            gapcnt_q <= gapcnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b0;
          fss_q   <= 1'b1;
          bsy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TxFRdPtrInc = ptr_inc_q;
  assign bus.SSPTXD      = txd_q;
  assign bus.SSPCLKOUT   = sck_level;
  assign bus.SSPFSSOUT   = fss_q;
  assign bus.TxBSY       = bsy_q;

endmodule
`default_nettype wire

// File: tb/tb_ssp_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssp_tx_shifter
// Description : Self-checking bench for ssp_tx_shifter. Stimulus pushes the
//               expected frame (bit count, bits, FSS-low length) into a
//               queue; a monitor reconstructs every frame from SSPFSSOUT,
//               SSPCLKOUT rising edges and SSPTXD and compares against it.
//               A second monitor counts and timestamps TxFRdPtrInc toggles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssp_tx_shifter;

  localparam int HOLDOFF = 6;

  typedef struct {
    int          nbits;
    logic [15:0] bits;
    int          low;
  } frame_t;

  logic SSPCLK = 1'b0;
  logic SSPRST = 1'b1;

  ssp_tx_shifter_if #(.DW(16)) bus ();

  ssp_tx_shifter #(.HOLDOFF(HOLDOFF), .DW(16)) dut (
    .SSPCLK (SSPCLK),
    .SSPRST (SSPRST),
    .bus    (bus)
  );

  always #5 SSPCLK = ~SSPCLK;

  int     n_chk = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     tog_count = 0;
  int     exp_toggles = 0;
  int     tog_cyc[$];
  frame_t exp_q[$];

  // frame monitor state
  bit          m_in_frame = 0;
  int          m_nb = 0;
  int          m_low = 0;
  logic [15:0] m_bits = '0;
  logic        m_sck_prev = 1'b0;
  frame_t      m_e;
  logic        tog_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int nbits, input logic [15:0] bits, input int low);
    frame_t f;
    f.nbits = nbits;
    f.bits  = bits;
    f.low   = low;
    exp_q.push_back(f);
  endtask

  // Pulse the FIFO-available flag for one cycle and return how many
  // sampled cycles TxBSY stays high from the start edge onwards.
  task automatic run_frame(input logic [3:0] dss, input logic [7:0] scr,
                           input logic [15:0] data, output int busy);
    @(negedge SSPCLK);
    bus.DSS = dss; bus.SCR = scr; bus.TxFRdData = data;
    bus.TxDataAvlblSync = 1'b1;
    @(posedge SSPCLK);
    @(negedge SSPCLK);
    bus.TxDataAvlblSync = 1'b0;
    exp_toggles++;
    busy = 0;
    for (int k = 0; k < 2000; k++) begin
      if (bus.TxBSY !== 1'b1) break;
      busy++;
      @(negedge SSPCLK);
    end
  endtask

  task automatic wait_tog(input int target, input int limit, input string name);
    int k;
    for (k = 0; k < limit; k++) begin
      if (tog_count >= target) break;
      @(negedge SSPCLK); #1;
    end
    if (k == limit) chk({name, "_timeout"}, tog_count, target);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge SSPCLK);
      if (bus.TxBSY === 1'b0) break;
    end
    if (k == limit) chk({name, "_idle_timeout"}, bus.TxBSY, 0);
  endtask

  task automatic chk_spacing(input string name, input int idx, input int req);
    if (tog_cyc.size() > idx) begin
      chk(name, tog_cyc[idx] - tog_cyc[idx-1], req);
    end else begin
      chk({name, "_missing"}, tog_cyc.size(), idx + 1);
    end
  endtask

  initial begin
    forever begin
      @(posedge SSPCLK);
      cyc++;
    end
  end

  // Toggle monitor; the level drop caused by reset is not a pop.
  initial begin
    forever begin
      @(negedge SSPCLK);
      if (SSPRST) begin
        tog_prev = bus.TxFRdPtrInc;
      end else if (bus.TxFRdPtrInc !== tog_prev) begin
        tog_count++;
        tog_cyc.push_back(cyc);
        tog_prev = bus.TxFRdPtrInc;
      end
    end
  end

  // Frame monitor / scoreboard consumer.
  initial begin
    forever begin
      @(negedge SSPCLK);
      if (bus.SSPFSSOUT === 1'b0) begin
        if (!m_in_frame) begin
          m_in_frame = 1; m_nb = 0; m_low = 0; m_bits = '0;
        end
        m_low++;
        if (bus.SSPCLKOUT === 1'b1 && m_sck_prev === 1'b0) begin
          m_bits = {m_bits[14:0], bus.SSPTXD};
          m_nb++;
        end
      end else if (m_in_frame) begin
        m_in_frame = 0;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL frame_unexpected: got %0d bits 0x%0h, required no frame", m_nb, m_bits);
        end else begin
          m_e = exp_q.pop_front();
          chk("frame_nbits", m_nb, m_e.nbits);
          chk("frame_bits", m_bits, m_e.bits);
          chk("frame_fss_low", m_low, m_e.low);
        end
      end
      m_sck_prev = bus.SSPCLKOUT;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int base;
    int rises;
    logic prev;

    bus.SSE = 1'b0; bus.DSS = 4'd7; bus.SCR = 8'd0;
    bus.TxDataAvlblSync = 1'b0; bus.TxFRdData = 16'h0000;

    // Reset state
    repeat (2) @(negedge SSPCLK);
    chk("rst_fss", bus.SSPFSSOUT, 1);
    chk("rst_clkout", bus.SSPCLKOUT, 0);
    chk("rst_txd", bus.SSPTXD, 0);
    chk("rst_bsy", bus.TxBSY, 0);
    chk("rst_ptrinc", bus.TxFRdPtrInc, 0);
    SSPRST = 1'b0;
    bus.SSE = 1'b1;
    repeat (3) @(negedge SSPCLK);

    // 1: 8-bit frame, SCR=0, 0xA5 -> 16 cycles FSS low, busy SHIFT+GAP
    push_exp(8, 16'h00A5, 16);
    run_frame(4'd7, 8'd0, 16'h00A5, busy);
    chk("t1_busy", busy, 17);
    repeat (3) @(negedge SSPCLK);
    chk("t1_toggles", tog_count, exp_toggles);

    // 2: 16-bit frame, SCR=2, avail held -> two frames 100 cycles apart
    base = tog_count;
    push_exp(16, 16'h8001, 96);
    push_exp(16, 16'h8001, 96);
    @(negedge SSPCLK);
    bus.DSS = 4'd15; bus.SCR = 8'd2; bus.TxFRdData = 16'h8001;
    bus.TxDataAvlblSync = 1'b1;
    wait_tog(base + 2, 400, "t2");
    bus.TxDataAvlblSync = 1'b0;
    exp_toggles += 2;
    wait_idle(400, "t2");
    chk_spacing("t2_spacing", base + 1, 100);
    repeat (3) @(negedge SSPCLK);
    chk("t2_toggles", tog_count, exp_toggles);

    // 3: early abort then avail held -> restart blocked by holdoff
    base = tog_count;
    push_exp(0, 16'h0000, 1);
    push_exp(4, 16'h0009, 8);
    push_exp(4, 16'h0009, 8);
    @(negedge SSPCLK);
    bus.DSS = 4'd3; bus.SCR = 8'd0; bus.TxFRdData = 16'h0009;
    bus.TxDataAvlblSync = 1'b1;
    @(posedge SSPCLK);
    @(negedge SSPCLK);
    bus.SSE = 1'b0;
    @(negedge SSPCLK);
    bus.SSE = 1'b1;
    wait_tog(base + 3, 200, "t3");
    bus.TxDataAvlblSync = 1'b0;
    exp_toggles += 3;
    wait_idle(200, "t3");
    chk_spacing("t3_holdoff_spacing", base + 1, HOLDOFF + 1);
    chk_spacing("t3_frame_spacing", base + 2, 10);
    repeat (3) @(negedge SSPCLK);
    chk("t3_toggles", tog_count, exp_toggles);

    // 4: drop SSE after 3 SCK rising edges, then a fresh frame
    push_exp(3, 16'h0006, 11);
    @(negedge SSPCLK);
    bus.DSS = 4'd7; bus.SCR = 8'd1; bus.TxFRdData = 16'h00C3;
    bus.TxDataAvlblSync = 1'b1;
    @(posedge SSPCLK);
    exp_toggles++;
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 200 && rises < 3; k++) begin
      @(negedge SSPCLK);
      bus.TxDataAvlblSync = 1'b0;
      if (bus.SSPCLKOUT === 1'b1 && prev === 1'b0) rises++;
      prev = bus.SSPCLKOUT;
    end
    chk("t4_rises", rises, 3);
    bus.SSE = 1'b0;
    @(negedge SSPCLK);
    chk("t4_abort_fss", bus.SSPFSSOUT, 1);
    chk("t4_abort_clkout", bus.SSPCLKOUT, 0);
    chk("t4_abort_bsy", bus.TxBSY, 0);
    chk("t4_abort_txd", bus.SSPTXD, 0);
    repeat (20) @(negedge SSPCLK);
    chk("t4_toggles_after_abort", tog_count, exp_toggles);
    bus.SSE = 1'b1;
    push_exp(8, 16'h005A, 32);
    run_frame(4'd7, 8'd1, 16'h005A, busy);
    chk("t4_fresh_busy", busy, 34);

    // 5: reserved DSS=1 -> 4-bit frame, upper data bits suppressed
    push_exp(4, 16'h0005, 8);
    run_frame(4'd1, 8'd0, 16'hFFF5, busy);
    chk("t5_busy", busy, 9);
    repeat (3) @(negedge SSPCLK);
    chk("t5_toggles", tog_count, exp_toggles);

    // 6: asynchronous reset mid-SHIFT
    push_exp(1, 16'h0001, 10);
    @(negedge SSPCLK);
    bus.DSS = 4'd7; bus.SCR = 8'd3; bus.TxFRdData = 16'h0081;
    bus.TxDataAvlblSync = 1'b1;
    @(posedge SSPCLK);
    exp_toggles++;
    @(negedge SSPCLK);
    bus.TxDataAvlblSync = 1'b0;
    repeat (10) @(posedge SSPCLK);
    #2 SSPRST = 1'b1;
    #1;
    chk("t6_rst_fss", bus.SSPFSSOUT, 1);
    chk("t6_rst_clkout", bus.SSPCLKOUT, 0);
    chk("t6_rst_txd", bus.SSPTXD, 0);
    chk("t6_rst_bsy", bus.TxBSY, 0);
    chk("t6_rst_ptrinc", bus.TxFRdPtrInc, 0);
    repeat (2) @(negedge SSPCLK);
    SSPRST = 1'b0;
    @(negedge SSPCLK);

    // post-reset frame starts immediately (holdoff cleared by reset)
    push_exp(4, 16'h000A, 8);
    run_frame(4'd3, 8'd0, 16'h000A, busy);
    chk("t6_post_busy", busy, 9);

    repeat (10) @(negedge SSPCLK);
    chk("final_toggles", tog_count, exp_toggles);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
